dpll_loop_ctrl: RTL and testbench

//  Parametrised loop controller for the all-digital PLL, in the pll_clk domain between PFD and DCO.
//  - Converts PFD up/down into a saturating PI control word for the DCO.
//  - Generates the feedback clock through a runtime-programmable divider.
//  - Replaces the single-cycle lock flag with a per-feedback-period lock detector that has hysteresis.

---
 rtl/dpll_pkg.sv | 37 +++
 rtl/dpll_fb_divider.sv | 46 ++++
 rtl/dpll_loop_ctrl.sv | 151 +++++++++++++++
 tb/tb_dpll_loop_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dpll_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dpll_pkg : shared types, control-word limits and saturating add for DPLL   |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
package dpll_pkg;

   typedef enum logic [0:0] {
      UNLOCKED = 1'b0,
      LOCKED   = 1'b1
   } lock_state_e;

   localparam int DPLL_CTRL_W = 16;
   localparam logic signed [DPLL_CTRL_W-1:0] CTRL_MIN = {1'b1, {(DPLL_CTRL_W-1){1'b0}}};
   localparam logic signed [DPLL_CTRL_W-1:0] CTRL_MAX = {1'b0, {(DPLL_CTRL_W-1){1'b1}}};

   // Adds at a width far above any control word, then clamps to a signed w-bit range
   function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                  input logic signed [63:0] b,
                                                  input int                 w);
      logic signed [63:0] v_sum;
      logic signed [63:0] v_hi;
      logic signed [63:0] v_lo;
      v_sum = a + b;
      v_hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
      v_lo  = -(64'sd1 <<< (w - 1));
      if (v_sum > v_hi) begin
         return v_hi;
      end
      if (v_sum < v_lo) begin
         return v_lo;
      end
      return v_sum;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dpll_fb_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dpll_fb_divider : programmable feedback divider with period-boundary latch |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module dpll_fb_divider
   import dpll_pkg::*;
#(
   parameter int DIV_W = 8
) (
   input  logic             pll_clk,
   input  logic             rst_n,
   input  logic [DIV_W-1:0] fb_div_n,
   output logic             clk_fb,
   output logic             tc
);

   localparam logic [DIV_W-1:0] c_min_div = DIV_W'(2);
   localparam logic [DIV_W-1:0] c_one     = DIV_W'(1);

   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_nl;
   logic             r_clk_fb;

   assign tc     = (r_cnt == (r_nl - c_one));
   assign clk_fb = r_clk_fb;

   // The ratio is only sampled at terminal count, so a mid-period change never shortens a pulse
   always_ff @(posedge pll_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt    <= '0;
         r_nl     <= c_min_div;
         r_clk_fb <= 1'b0;
      end else begin
         r_clk_fb <= (r_cnt < (r_nl >> 1));
         if (tc) begin
            r_cnt <= '0;
            r_nl  <= (fb_div_n < c_min_div) ? c_min_div : fb_div_n;
         end else begin
            r_cnt <= r_cnt + c_one;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/dpll_loop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dpll_loop_ctrl : PI loop filter, feedback divider and hysteretic lock det. |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module dpll_loop_ctrl
   import dpll_pkg::*;
#(
   parameter int CTRL_W     = DPLL_CTRL_W,
   parameter int DIV_W      = 8,
   parameter int KP_SHIFT   = 4,
   parameter int KI_SHIFT   = 0,
   parameter int LOCK_TOL   = 2,
   parameter int LOCK_CNT   = 16,
   parameter int UNLOCK_CNT = 4
) (
   input  logic                     pll_clk,
   input  logic                     rst_n,
   input  logic                     up,
   input  logic                     down,
   input  logic [DIV_W-1:0]         fb_div_n,
   output logic signed [CTRL_W-1:0] ctrl_word,
   output logic                     clk_fb,
   output logic                     locked,
   output logic                     lock_lost,
   output logic                     sat
);

   localparam int c_ecnt_w = $clog2(LOCK_TOL + 2);
   localparam int c_qcnt_w = $clog2(LOCK_CNT + 1);
   localparam int c_ncnt_w = $clog2(UNLOCK_CNT + 1);

   localparam logic [c_ecnt_w-1:0] c_ecnt_sat  = c_ecnt_w'(LOCK_TOL + 1);
   localparam logic [c_ecnt_w-1:0] c_ecnt_tol  = c_ecnt_w'(LOCK_TOL);
   localparam logic [c_qcnt_w-1:0] c_qcnt_last = c_qcnt_w'(LOCK_CNT - 1);
   localparam logic [c_ncnt_w-1:0] c_ncnt_last = c_ncnt_w'(UNLOCK_CNT - 1);

   localparam logic signed [63:0] c_ctrl_hi = (64'sd1 <<< (CTRL_W - 1)) - 64'sd1;
   localparam logic signed [63:0] c_ctrl_lo = -(64'sd1 <<< (CTRL_W - 1));

   localparam logic [0:0] c_st_unlocked = UNLOCKED;
   localparam logic [0:0] c_st_locked   = LOCKED;

   logic signed [CTRL_W-1:0] r_integ;
   logic signed [CTRL_W-1:0] r_ctrl_word;
   logic                     r_sat;
   logic [0:0]               r_state;
   logic [c_ecnt_w-1:0]      r_ecnt;
   logic [c_qcnt_w-1:0]      r_qcnt;
   logic [c_ncnt_w-1:0]      r_ncnt;
   logic                     r_lock_lost;

   logic                     w_tc;
   logic                     w_err_cyc;
   logic signed [63:0]       w_err;
   logic signed [63:0]       w_integ_next;
   logic signed [63:0]       w_ctrl_next;
   logic [c_ecnt_w-1:0]      w_ecnt_tot;
   logic                     w_quiet;
   logic [0:0]               w_state_nx;
   logic [c_qcnt_w-1:0]      w_qcnt_nx;
   logic [c_ncnt_w-1:0]      w_ncnt_nx;
   logic                     w_lost_nx;

   dpll_fb_divider #(
      .DIV_W (DIV_W)
   ) u_fb_divider (
      .pll_clk  (pll_clk),
      .rst_n    (rst_n),
      .fb_div_n (fb_div_n),
      .clk_fb   (clk_fb),
      .tc       (w_tc)
   );

   // Proportional kick rides on the already-clamped integrator, so leaving the rail has no windup
   always_comb begin
      w_err_cyc = up ^ down;
      if (up && !down) begin
         w_err = 64'sd1;
      end else if (down && !up) begin
         w_err = -64'sd1;
      end else begin
         w_err = 64'sd0;
      end
      w_integ_next = sat_add(64'(r_integ), w_err <<< KI_SHIFT, CTRL_W);
      w_ctrl_next  = sat_add(w_integ_next, w_err <<< KP_SHIFT, CTRL_W);
   end

   always_comb begin
      w_ecnt_tot = r_ecnt;
      if (w_err_cyc && (r_ecnt != c_ecnt_sat)) begin
         w_ecnt_tot = r_ecnt + c_ecnt_w'(1);
      end
      w_quiet    = (w_ecnt_tot <= c_ecnt_tol);
      w_state_nx = r_state;
      w_qcnt_nx  = r_qcnt;
      w_ncnt_nx  = r_ncnt;
      w_lost_nx  = 1'b0;
      if (w_tc) begin
         if (r_state == c_st_unlocked) begin
            if (!w_quiet) begin
               w_qcnt_nx = '0;
            end else if (r_qcnt == c_qcnt_last) begin
               w_state_nx = c_st_locked;
               w_qcnt_nx  = '0;
            end else begin
               w_qcnt_nx = r_qcnt + c_qcnt_w'(1);
            end
         end else begin
            if (w_quiet) begin
               w_ncnt_nx = '0;
            end else if (r_ncnt == c_ncnt_last) begin
               w_state_nx = c_st_unlocked;
               w_ncnt_nx  = '0;
               w_lost_nx  = 1'b1;
            end else begin
               w_ncnt_nx = r_ncnt + c_ncnt_w'(1);
            end
         end
      end
   end

   always_ff @(posedge pll_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_integ     <= '0;
         r_ctrl_word <= '0;
         r_sat       <= 1'b0;
         r_state     <= c_st_unlocked;
         r_ecnt      <= '0;
         r_qcnt      <= '0;
         r_ncnt      <= '0;
         r_lock_lost <= 1'b0;
      end else begin
         r_integ     <= CTRL_W'(w_integ_next);
         r_ctrl_word <= CTRL_W'(w_ctrl_next);
         r_sat       <= (w_ctrl_next == c_ctrl_hi) || (w_ctrl_next == c_ctrl_lo);
         r_state     <= w_state_nx;
         r_ecnt      <= w_tc ? '0 : w_ecnt_tot;
         r_qcnt      <= w_qcnt_nx;
         r_ncnt      <= w_ncnt_nx;
         r_lock_lost <= w_lost_nx;
      end
   end

   assign ctrl_word = r_ctrl_word;
   assign sat       = r_sat;
   assign locked    = (r_state == c_st_locked);
   assign lock_lost = r_lock_lost;

endmodule
`default_nettype wire

// File: tb/tb_dpll_loop_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_dpll_loop_ctrl : directed vector bench for dpll_loop_ctrl               |
// | Rev 1.0  : initial release                                                 |
// +----------------------------------------------------------------------------+
module tb_dpll_loop_ctrl;

   logic               pll_clk = 1'b0;
   logic               rst_n   = 1'b0;
   logic               up      = 1'b0;
   logic               down    = 1'b0;
   logic [7:0]         fb_div_n = 8'd10;
   logic signed [15:0] ctrl_word;
   logic               clk_fb;
   logic               locked;
   logic               lock_lost;
   logic               sat;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic up;
      logic down;
      int   exp_ctrl;
      logic exp_sat;
   } vec_t;

   vec_t vecs[11];

   dpll_loop_ctrl dut (
      .pll_clk   (pll_clk),
      .rst_n     (rst_n),
      .up        (up),
      .down      (down),
      .fb_div_n  (fb_div_n),
      .ctrl_word (ctrl_word),
      .clk_fb    (clk_fb),
      .locked    (locked),
      .lock_lost (lock_lost),
      .sat       (sat)
   );

   initial forever #5 pll_clk = ~pll_clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick(input logic u, input logic d);
      up   = u;
      down = d;
      @(posedge pll_clk);
      #1;
   endtask

   task automatic do_reset();
      up    = 1'b0;
      down  = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge pll_clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One feedback period of 10 cycles with nerr error cycles, alternating up and down
   task automatic period(input int nerr);
      for (int i = 0; i < 10; i++) begin
         tick((i < nerr) && (i % 2 == 0), (i < nerr) && (i % 2 == 1));
      end
   endtask

   function automatic int exp_fb(input int k);
      if (k <= 2)  return k % 2;
      if (k <= 7)  return 1;
      if (k <= 12) return 0;
      if (k <= 15) return 1;
      if (k <= 19) return 0;
      if (k <= 22) return 1;
      if (k <= 26) return 0;
      if (k <= 29) return 1;
      if (k <= 33) return 0;
      return (k % 2 == 0) ? 1 : 0;
   endfunction

   initial begin
      int prev_ctrl;
      int wraps;

      vecs[0]  = '{1'b1, 1'b0,  17, 1'b0};
      vecs[1]  = '{1'b0, 1'b0,   1, 1'b0};
      vecs[2]  = '{1'b1, 1'b1,   1, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, -16, 1'b0};
      vecs[4]  = '{1'b0, 1'b0,   0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, -17, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, -18, 1'b0};
      vecs[7]  = '{1'b0, 1'b0,  -2, 1'b0};
      vecs[8]  = '{1'b1, 1'b0,  15, 1'b0};
      vecs[9]  = '{1'b1, 1'b0,  16, 1'b0};
      vecs[10] = '{1'b0, 1'b0,   0, 1'b0};

      // Reset state and lock acquisition with N=10
      fb_div_n = 8'd10;
      do_reset();
      check("rst_ctrl", int'(ctrl_word), 0);
      check("rst_locked", int'(locked), 0);
      check("rst_sat", int'(sat), 0);
      check("rst_clk_fb", int'(clk_fb), 0);
      check("rst_lock_lost", int'(lock_lost), 0);
      for (int k = 1; k <= 151; k++) tick(1'b0, 1'b0);
      check("lock_before_16th_tc", int'(locked), 0);
      tick(1'b0, 1'b0);
      check("lock_after_16th_tc", int'(locked), 1);
      check("idle_ctrl", int'(ctrl_word), 0);

      // PI step responses from a zero integrator
      for (int i = 0; i < 11; i++) begin
         tick(vecs[i].up, vecs[i].down);
         check($sformatf("pi_vec%0d_ctrl", i), int'(ctrl_word), vecs[i].exp_ctrl);
         check($sformatf("pi_vec%0d_sat", i), int'(sat), int'(vecs[i].exp_sat));
      end

      // Saturation at the positive rail and recovery without windup
      do_reset();
      wraps     = 0;
      prev_ctrl = 0;
      for (int k = 1; k <= 40000; k++) begin
         tick(1'b1, 1'b0);
         if (int'(ctrl_word) < prev_ctrl) wraps++;
         prev_ctrl = int'(ctrl_word);
         if (k == 32750) begin
            check("ramp_pre_rail_ctrl", int'(ctrl_word), 32766);
            check("ramp_pre_rail_sat", int'(sat), 0);
         end
         if (k == 32751) begin
            check("ramp_rail_ctrl", int'(ctrl_word), 32767);
            check("ramp_rail_sat", int'(sat), 1);
         end
      end
      check("ramp_no_wrap", wraps, 0);
      check("hold_ctrl", int'(ctrl_word), 32767);
      check("hold_sat", int'(sat), 1);
      tick(1'b0, 1'b1);
      check("down1_ctrl", int'(ctrl_word), 32750);
      check("down1_sat", int'(sat), 0);
      tick(1'b0, 1'b1);
      check("down2_ctrl", int'(ctrl_word), 32749);

      // Lock hysteresis: 2 errors per period keeps lock, 3 errors for 4 periods drops it
      fb_div_n = 8'd10;
      do_reset();
      for (int k = 1; k <= 152; k++) tick(1'b0, 1'b0);
      check("relock", int'(locked), 1);
      for (int p = 0; p < 4; p++) begin
         period(2);
         check($sformatf("tol2_p%0d_locked", p), int'(locked), 1);
         check($sformatf("tol2_p%0d_lost", p), int'(lock_lost), 0);
      end
      for (int p = 0; p < 3; p++) begin
         period(3);
         check($sformatf("noisy_p%0d_locked", p), int'(locked), 1);
      end
      for (int i = 0; i < 9; i++) tick((i < 3) && (i % 2 == 0), (i < 3) && (i % 2 == 1));
      check("noisy_p3_before_tc_locked", int'(locked), 1);
      tick(1'b0, 1'b0);
      check("noisy_p3_locked", int'(locked), 0);
      check("noisy_p3_lost_pulse", int'(lock_lost), 1);
      tick(1'b0, 1'b0);
      check("lost_pulse_end", int'(lock_lost), 0);
      check("stays_unlocked", int'(locked), 0);

      // Divider ratio change mid-period, then ratios below 2
      fb_div_n = 8'd10;
      do_reset();
      for (int k = 1; k <= 46; k++) begin
         if (k == 6)  fb_div_n = 8'd7;
         if (k == 27) fb_div_n = 8'd0;
         if (k == 41) fb_div_n = 8'd1;
         tick(1'b0, 1'b0);
         check($sformatf("clk_fb_tick%0d", k), int'(clk_fb), exp_fb(k));
      end

      // Both PFD outputs high: no error, still locks; then async reset mid-lock
      fb_div_n = 8'd10;
      do_reset();
      for (int k = 1; k <= 151; k++) tick(1'b1, 1'b1);
      check("both_high_pre_lock", int'(locked), 0);
      tick(1'b1, 1'b1);
      check("both_high_locked", int'(locked), 1);
      check("both_high_ctrl", int'(ctrl_word), 0);
      tick(1'b1, 1'b0);
      tick(1'b0, 1'b0);
      check("pre_arst_ctrl", int'(ctrl_word), 1);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_ctrl", int'(ctrl_word), 0);
      check("arst_locked", int'(locked), 0);
      check("arst_sat", int'(sat), 0);
      check("arst_clk_fb", int'(clk_fb), 0);
      check("arst_lock_lost", int'(lock_lost), 0);
      @(posedge pll_clk);
      #1;
      rst_n = 1'b1;
      tick(1'b0, 1'b0);
      check("post_arst_t1_clk_fb", int'(clk_fb), 1);
      tick(1'b0, 1'b0);
      check("post_arst_t2_clk_fb", int'(clk_fb), 0);
      tick(1'b0, 1'b0);
      check("post_arst_t3_clk_fb", int'(clk_fb), 1);
      for (int k = 4; k <= 8; k++) tick(1'b0, 1'b0);
      check("post_arst_t8_clk_fb", int'(clk_fb), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
